// File: rtl/spi_result_pkg.sv
// Shared types and constants for the SPI result readout slave.
package spi_result_pkg;

  // Frame-level state of the slave.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // First byte of every frame unless overridden.
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Header byte plus status byte precede the result words.
  localparam int PREAMBLE_BITS = 16;

  // Command byte length received on MOSI at the start of each frame.
  localparam int CMD_BITS = 8;

  // Total number of bits clocked out in one frame.
  function automatic int frame_bits(input int num_words, input int word_w);
    return PREAMBLE_BITS + num_words * word_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous pin with registered rise/fall detection.
// The level output is aligned with the edge pulses, so downstream logic sees
// a consistent (level, edge) pair in the same cycle.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // Metastability chain; resets to the pin's idle level so no edge is seen after reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{INIT}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  // Registered edge detection on the synchronised level.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_result_slave.sv
// SPI slave that streams a frame {HEADER, status, result words} to a master.
// Results are captured into a shadow register on word_valid; the shadow is
// copied into the shift register only at frame start so a frame is atomic.
module spi_result_slave
  import spi_result_pkg::*;
#(
  parameter int         NUM_WORDS   = 3,
  parameter int         WORD_W      = 32,
  parameter int         CPOL        = 0,
  parameter int         CPHA        = 0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic [NUM_WORDS*WORD_W-1:0]   word_data,
  input  logic                          word_valid,
  input  logic                          nCS,
  input  logic                          SCK,
  input  logic                          MOSI,
  output logic                          MISO,
  output logic                          busy,
  output logic [7:0]                    cmd_byte,
  output logic                          cmd_valid,
  output logic                          frame_done,
  output logic                          frame_abort
);

  localparam int FB     = frame_bits(NUM_WORDS, WORD_W);
  localparam int CNT_W  = $clog2(FB + 1);
  localparam int DATA_W = NUM_WORDS * WORD_W;

  localparam logic             SCK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(CMD_BITS);

  // ---------------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------------
  logic sck_lvl, sck_rise, sck_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic [SYNC_STAGES:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .INIT   (SCK_IDLE)
  ) u_sck_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .d_i     (SCK),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .INIT   (1'b1)
  ) u_ncs_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .d_i     (nCS),
    .level_o (ncs_lvl),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  // MOSI chain is one stage longer so it lines up with the registered SCK edge pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-1:0], MOSI};
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES];

  // Leading edge leaves the idle level, trailing edge returns to it.
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_lvl != SCK_IDLE);
  assign trail_edge  = sck_edge & (sck_lvl == SCK_IDLE);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [FB-1:0]       shift_q, shift_d;
  logic                miso_q, miso_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          cmd_sr_q, cmd_sr_d;
  logic [7:0]          cmd_byte_q, cmd_byte_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_abort_q, frame_abort_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic                fresh_q, fresh_d;
  logic                overrun_q, overrun_d;
  logic [5:0]          seq_q, seq_d;

  logic                load_en, shift_en, sample_en;
  logic [FB-1:0]       frame_w;

  // Snapshot of everything the master will see, taken at the frame-start cycle.
  assign frame_w = {HEADER, fresh_q, overrun_q, seq_q, shadow_q};

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: chip select opens/closes the frame, the last sample completes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (ncs_rise)                               state_d = IDLE;
        else if (sample_edge && (cnt_q == CNT_LAST)) state_d = DONE;
      end
      DONE: begin
        if (ncs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: SCK edges only act inside SHIFT, and a chip-select rise overrides them.
  always_comb begin
    load_en       = 1'b0;
    shift_en      = 1'b0;
    sample_en     = 1'b0;
    frame_abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        load_en = ncs_fall;
      end
      SHIFT: begin
        frame_abort_d = ncs_rise;
        shift_en      = ~ncs_rise & shift_edge;
        sample_en     = ~ncs_rise & sample_edge;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------

  // Shift register and MISO: CPHA=0 presents the MSB at load, CPHA=1 on the first leading edge.
  always_comb begin
    shift_d = shift_q;
    miso_d  = miso_q;
    if (load_en) begin
      if (CPHA != 0) begin
        shift_d = frame_w;
        miso_d  = 1'b0;
      end else begin
        shift_d = {frame_w[FB-2:0], 1'b0};
        miso_d  = frame_w[FB-1];
      end
    end else if (shift_en) begin
      miso_d  = shift_q[FB-1];
      shift_d = {shift_q[FB-2:0], 1'b0};
    end else if (state_d != SHIFT) begin
      miso_d = 1'b0;
    end
  end

  // Bit counter and command byte capture; the counter holds in DONE.
  always_comb begin
    cnt_d        = cnt_q;
    cmd_sr_d     = cmd_sr_q;
    cmd_byte_d   = cmd_byte_q;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (load_en) begin
      cnt_d    = '0;
      cmd_sr_d = '0;
    end else if (sample_en) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q < CMD_END) cmd_sr_d = {cmd_sr_q[5:0], mosi_s};
      if (cnt_q == CMD_LAST) begin
        cmd_byte_d  = {cmd_sr_q, mosi_s};
        cmd_valid_d = 1'b1;
      end
      if (cnt_q == CNT_LAST) frame_done_d = 1'b1;
    end
  end

  // Shadow capture; a new result beats the end-of-frame clear of fresh/overrun.
  always_comb begin
    shadow_d  = shadow_q;
    fresh_d   = fresh_q;
    overrun_d = overrun_q;
    seq_d     = seq_q;
    if (word_valid) begin
      shadow_d  = word_data;
      fresh_d   = 1'b1;
      overrun_d = frame_done_q ? fresh_q : (overrun_q | fresh_q);
      seq_d     = seq_q + 6'd1;
    end else if (frame_done_q) begin
      fresh_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q       <= '0;
      miso_q        <= 1'b0;
      cnt_q         <= '0;
      cmd_sr_q      <= '0;
      cmd_byte_q    <= '0;
      cmd_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      shadow_q      <= '0;
      fresh_q       <= 1'b0;
      overrun_q     <= 1'b0;
      seq_q         <= '0;
    end else begin
      shift_q       <= shift_d;
      miso_q        <= miso_d;
      cnt_q         <= cnt_d;
      cmd_sr_q      <= cmd_sr_d;
      cmd_byte_q    <= cmd_byte_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      shadow_q      <= shadow_d;
      fresh_q       <= fresh_d;
      overrun_q     <= overrun_d;
      seq_q         <= seq_d;
    end
  end

  assign MISO        = miso_q;
  assign busy        = ~ncs_lvl;
  assign cmd_byte    = cmd_byte_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: doc/spi_result_slave.md
# spi_result_slave

Parametrised SPI slave that serves a frame of counter results (e.g. fs_cnt, fx_cnt, reference constant) to an external master. Results are captured into a shadow register on a valid strobe. The shadow is copied atomically into the shift register at frame start, so a word never changes mid-transfer. Compared with the fixed 96-bit, mode-0-only readout, this block adds SPI mode selection, a header/status preamble with a freshness/overrun/sequence byte, and an 8-bit command byte received on MOSI.

## Interface
Parameters:
- NUM_WORDS, 3: number of result words in the frame.
- WORD_W, 32: width of each word.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth for SCK, nCS and MOSI (≥2).
- HEADER, 8'hA5: first byte of every frame.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- word_data  in  NUM_WORDS*WORD_W  results; word k = word_data[k*WORD_W +: WORD_W].
- word_valid  in  1  one-cycle strobe; capture word_data into the shadow register.
- nCS  in  1  chip select, active low, asynchronous.
- SCK  in  1  SPI clock, asynchronous.
- MOSI  in  1  master data, asynchronous.
- MISO  out  1  slave data, registered.
- busy  out  1  high while a frame is in progress (nCS_s low).
- cmd_byte  out  8  first byte received on MOSI in the current or last frame.
- cmd_valid  out  1  one-cycle pulse when cmd_byte updates.
- frame_done  out  1  one-cycle pulse when all FRAME_BITS have been sampled.
- frame_abort  out  1  one-cycle pulse when nCS rises before frame completion.

## Operation
- FRAME_BITS = 16 + NUM_WORDS*WORD_W, sent MSB-first in this order:
  - HEADER;
  - status byte = {fresh, overrun, seq[5:0]};
  - word NUM_WORDS-1 down to word 0.
- Shadow capture: word_valid loads the shadow register, sets fresh, and increments seq (6-bit, wraps 63→0).
  - If fresh is already 1 when word_valid arrives, overrun is set.
  - Capture happens in every state; the shift register is unaffected.
- A completed frame (frame_done) clears fresh and overrun.
  - If word_valid coincides with frame_done, the capture wins: fresh=1, and overrun is set only if fresh was 1 before.
- Leading edge = SCK_s leaving CPOL; trailing edge = SCK_s returning to CPOL.
- CPHA=0:
  - MISO presents bit FRAME_BITS-1 on the nCS_s fall.
  - Sample on leading edges; shift on trailing edges.
- CPHA=1:
  - Shift on each leading edge; the first leading edge presents the MSB.
  - Sample on trailing edges.
- MOSI is sampled on every sampling edge. After the 8th sample, cmd_byte is loaded and cmd_valid pulses. Later MOSI bits are ignored.
- State machine:
  - IDLE: MISO=0. On nCS_s fall: load shift register from {HEADER, status, shadow}, clear the bit counter, go to SHIFT.
  - SHIFT: count sampling edges. At count FRAME_BITS: pulse frame_done, go to DONE. On nCS_s rise: pulse frame_abort, go to IDLE; fresh, overrun and the shadow are unchanged.
  - DONE: MISO=0; further SCK edges ignored. On nCS_s rise, go to IDLE.
- SCK edges while nCS_s is high are ignored.
- The bit counter is $clog2(FRAME_BITS+1) bits wide and saturates in DONE.

## Timing
- Reset values: MISO=0, busy=0, cmd_byte=0, cmd_valid=0, frame_done=0, frame_abort=0. Internally shadow=0, seq=0, fresh=0, overrun=0, state IDLE.
- Latency from any pin transition (nCS, SCK) to its effect on MISO or the state: SYNC_STAGES+2 sys_clk cycles (synchroniser, edge-detect register, output register).
- Constraint: f_sys_clk ≥ 8×f_SCK. Each SCK half-period must be ≥ 4 sys_clk cycles at SYNC_STAGES=2.
- Pulses:
  - frame_done: 1 cycle after the detected final sampling edge.
  - cmd_valid: 1 cycle after the detected 8th sampling edge.
  - frame_abort: 1 cycle after the detected nCS_s rise.
- The status byte reflects fresh/overrun/seq as they stood in the cycle the nCS_s fall was detected.
- Reset mid-frame returns to IDLE immediately; MISO=0.

## Structure
- Package spi_result_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - default HEADER constant;
  - function frame_bits(NUM_WORDS, WORD_W).
- Sub-module spi_sync_edge: SYNC_STAGES flop chain plus registered rise/fall detect. Instantiated for SCK and nCS; MOSI uses sync only.

## Test plan
- Defaults, mode 0, word_data={32'h1234_5678, 32'h0000_00FF, 32'd200_000_000}, one word_valid, 112-clock read → MISO = A5, 0x81, then the three words MSB-first; frame_done pulses once.
- Second read with no new word_valid → status byte 0x01 (fresh=0); data identical.
- Three word_valid strobes without a read → status 0xC3; after a complete frame, next status 0x03.
- CPOL=1, CPHA=1, master sends MOSI 0x3C → cmd_byte=0x3C with one cmd_valid pulse; MISO stream bit-exact with mode 0.
- nCS raised after 20 bits → frame_abort pulses, no frame_done; next read still reports fresh=1.
- word_valid with new data during a frame → current frame carries the old snapshot; next frame carries the new one with seq+1. Extra SCK edges after bit 112 → MISO stays 0.
